voice_envelope: RTL and testbench

VOICE_ENVELOPE -- requirements
Module: voice_envelope

---
 rtl/synth_pkg.sv | 21 ++
 rtl/envelope_step.sv | 60 ++++++
 rtl/voice_envelope.sv | 100 ++++++++++
 tb/tb_voice_envelope.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/synth_pkg.sv
// Shared types and constants for the voice envelope block.
package synth_pkg;

  localparam int unsigned N_VOICES   = 8;
  localparam int unsigned IDX_W      = 3;
  localparam int unsigned LEVEL_W    = 32;
  localparam logic [31:0] FULL_SCALE = 32'h0001_0000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ATTACK,
    ST_DECAY,
    ST_SUSTAIN,
    ST_RELEASE
  } env_state_t;

  function automatic logic [31:0] clamp_sustain(input logic [31:0] sustain_level);
    return (sustain_level > FULL_SCALE) ? FULL_SCALE : sustain_level;
  endfunction

endpackage

// File: rtl/envelope_step.sv
// One ADSR update for a single voice; shared by the time-multiplexed scan.
module envelope_step
  import synth_pkg::*;
(
  input  env_state_t  state,
  input  logic [31:0] level,
  input  logic [31:0] attack_rate,
  input  logic [31:0] decay_rate,
  input  logic [31:0] release_rate,
  input  logic [31:0] sustain_level,
  output env_state_t  next_state,
  output logic [31:0] next_level
);

  logic [31:0] sus;
  logic [32:0] sum_attack;
  logic [32:0] diff_decay;
  logic [32:0] diff_release;

  always_comb begin
    // NOTE: outputs get a default first so no path can infer a latch.
    next_state   = state;
    next_level   = level;
    sus          = clamp_sustain(sustain_level);
    // 33-bit arithmetic: bit 32 flags overflow/borrow before it can wrap the level.
    sum_attack   = {1'b0, level} + {1'b0, attack_rate};
    diff_decay   = {1'b0, level} - {1'b0, decay_rate};
    diff_release = {1'b0, level} - {1'b0, release_rate};

    unique case (state)
      ST_ATTACK: if (attack_rate != '0) begin
        if (sum_attack >= {1'b0, FULL_SCALE}) begin
          next_level = FULL_SCALE;
          next_state = ST_DECAY;
        end else begin
          next_level = sum_attack[31:0];
        end
      end
      ST_DECAY: if (decay_rate != '0) begin
        if (diff_decay[32] || diff_decay[31:0] <= sus) begin
          next_level = sus;
          next_state = ST_SUSTAIN;
        end else begin
          next_level = diff_decay[31:0];
        end
      end
      ST_SUSTAIN: next_level = sus;
      ST_RELEASE: if (release_rate != '0) begin
        if (diff_release[32] || diff_release[31:0] == '0) begin
          next_level = '0;
          next_state = ST_IDLE;
        end else begin
          next_level = diff_release[31:0];
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/voice_envelope.sv
// Eight-voice ADSR envelope generator; one voice updated per cycle after env_tick.
module voice_envelope
  import synth_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        env_tick,
  input  logic        ev_valid,
  output logic        ev_ready,
  input  logic [2:0]  ev_voice,
  input  logic        ev_gate,
  input  logic [31:0] attack_rate,
  input  logic [31:0] decay_rate,
  input  logic [31:0] release_rate,
  input  logic [31:0] sustain_level,
  output logic [31:0] voice_volumes [N_VOICES-1:0],
  output logic [7:0]  active,
  output logic        tick_overrun
);

  env_state_t        state_q [N_VOICES-1:0];
  env_state_t        state_d [N_VOICES-1:0];
  logic [31:0]       level_q [N_VOICES-1:0];
  logic [31:0]       level_d [N_VOICES-1:0];
  logic              busy_q, busy_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              overrun_q, overrun_d;
  env_state_t        step_state;
  logic [31:0]       step_level;

  envelope_step u_step (
    .state         (state_q[idx_q]),
    .level         (level_q[idx_q]),
    .attack_rate   (attack_rate),
    .decay_rate    (decay_rate),
    .release_rate  (release_rate),
    .sustain_level (sustain_level),
    .next_state    (step_state),
    .next_level    (step_level)
  );

  always_comb begin
    state_d   = state_q;
    level_d   = level_q;
    busy_d    = busy_q;
    idx_d     = idx_q;
    overrun_d = overrun_q | (env_tick & busy_q);

    if (busy_q) begin
      state_d[idx_q] = step_state;
      level_d[idx_q] = step_level;
      idx_d          = idx_q + 1'b1;
      if (idx_q == IDX_W'(N_VOICES - 1)) busy_d = 1'b0;
    end else begin
      // Events land before a same-cycle tick, so the scan sees the new state.
      if (ev_valid) begin
        if (ev_gate) begin
          state_d[ev_voice] = ST_ATTACK;
        end else if (state_q[ev_voice] inside {ST_ATTACK, ST_DECAY, ST_SUSTAIN}) begin
          state_d[ev_voice] = ST_RELEASE;
        end
      end
      if (env_tick) begin
        busy_d = 1'b1;
        idx_d  = '0;
      end
    end
  end

  // NOTE: the per-voice arrays are plain flops and are reset, so voices start IDLE at 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_VOICES; i++) begin
        state_q[i] <= ST_IDLE;
        level_q[i] <= '0;
      end
      busy_q    <= 1'b0;
      idx_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      state_q   <= state_d;
      level_q   <= level_d;
      busy_q    <= busy_d;
      idx_q     <= idx_d;
      overrun_q <= overrun_d;
    end
  end

  always_comb begin
    for (int i = 0; i < N_VOICES; i++) begin
      voice_volumes[i] = level_q[i];
      active[i]        = (state_q[i] != ST_IDLE);
    end
  end

  assign ev_ready     = ~busy_q;
  assign tick_overrun = overrun_q;

endmodule

// File: tb/tb_voice_envelope.sv
// Directed self-checking bench for voice_envelope with hand-computed levels.
module tb_voice_envelope;

  logic        clk = 1'b0;
  logic        reset;
  logic        env_tick;
  logic        ev_valid;
  logic        ev_ready;
  logic [2:0]  ev_voice;
  logic        ev_gate;
  logic [31:0] attack_rate;
  logic [31:0] decay_rate;
  logic [31:0] release_rate;
  logic [31:0] sustain_level;
  logic [31:0] voice_volumes [7:0];
  logic [7:0]  active;
  logic        tick_overrun;

  int n_checks = 0;
  int n_errors = 0;

  voice_envelope dut (
    .clk           (clk),
    .reset         (reset),
    .env_tick      (env_tick),
    .ev_valid      (ev_valid),
    .ev_ready      (ev_ready),
    .ev_voice      (ev_voice),
    .ev_gate       (ev_gate),
    .attack_rate   (attack_rate),
    .decay_rate    (decay_rate),
    .release_rate  (release_rate),
    .sustain_level (sustain_level),
    .voice_volumes (voice_volumes),
    .active        (active),
    .tick_overrun  (tick_overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one cycle; inputs and samples live 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  // Tick and wait out the full scan; returns in cycle T+9 with all voices updated.
  task automatic do_tick();
    env_tick = 1'b1;
    step();
    env_tick = 1'b0;
    repeat (8) step();
  endtask

  task automatic send_event(input logic [2:0] voice, input logic gate);
    check("ev_ready_before_event", {31'd0, ev_ready}, 32'd1);
    ev_valid = 1'b1;
    ev_voice = voice;
    ev_gate  = gate;
    step();
    ev_valid = 1'b0;
  endtask

  task automatic set_rates(input logic [31:0] a, input logic [31:0] d,
                           input logic [31:0] s, input logic [31:0] r);
    attack_rate   = a;
    decay_rate    = d;
    sustain_level = s;
    release_rate  = r;
  endtask

  task automatic check_all_quiet(input string tag);
    for (int i = 0; i < 8; i++) check($sformatf("%s_vol%0d", tag, i), voice_volumes[i], 32'd0);
    check({tag, "_active"}, {24'd0, active}, 32'd0);
    check({tag, "_ev_ready"}, {31'd0, ev_ready}, 32'd1);
  endtask

  initial begin
    env_tick = 1'b0;
    ev_valid = 1'b0;
    ev_voice = '0;
    ev_gate  = 1'b0;
    set_rates(32'h4000, 32'h1000, 32'h8000, 32'h2000);
    do_reset();

    // Reset state
    check_all_quiet("reset");
    check("reset_overrun", {31'd0, tick_overrun}, 32'd0);

    // Full ADSR on voice 0
    send_event(3'd0, 1'b1);
    check("v0_active_on", {31'd0, active[0]}, 32'd1);
    check("v0_level_unchanged_by_event", voice_volumes[0], 32'd0);
    for (int i = 1; i <= 4; i++) begin
      do_tick();
      check($sformatf("v0_attack_%0d", i), voice_volumes[0], 32'h4000 * i);
    end
    for (int i = 1; i <= 8; i++) begin
      do_tick();
      check($sformatf("v0_decay_%0d", i), voice_volumes[0], 32'h10000 - 32'h1000 * i);
    end
    do_tick();
    check("v0_sustain_hold", voice_volumes[0], 32'h8000);
    sustain_level = 32'h0002_0000;
    do_tick();
    check("v0_sustain_clamped", voice_volumes[0], 32'h10000);
    sustain_level = 32'h8000;
    do_tick();
    check("v0_sustain_track", voice_volumes[0], 32'h8000);
    check("v1_untouched", voice_volumes[1], 32'd0);
    send_event(3'd0, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      do_tick();
      check($sformatf("v0_release_%0d", i), voice_volumes[0], 32'h8000 - 32'h2000 * i);
    end
    check("v0_idle_active", {31'd0, active[0]}, 32'd0);
    send_event(3'd0, 1'b0);
    check("v0_noteoff_in_idle", {31'd0, active[0]}, 32'd0);

    // Saturation on voice 1
    attack_rate = 32'h0003_0000;
    send_event(3'd1, 1'b1);
    do_tick();
    check("v1_attack_sat", voice_volumes[1], 32'h10000);
    do_tick();
    check("v1_in_decay", voice_volumes[1], 32'hF000);
    decay_rate = 32'h8000;
    do_tick();
    check("v1_decay_floor", voice_volumes[1], 32'h8000);
    release_rate = 32'hFFFF_FFFF;
    send_event(3'd1, 1'b0);
    do_tick();
    check("v1_release_nowrap", voice_volumes[1], 32'd0);
    check("v1_idle", {31'd0, active[1]}, 32'd0);

    // Handshake timing with voice 7 running
    set_rates(32'h4000, 32'h1000, 32'h8000, 32'h2000);
    send_event(3'd7, 1'b1);
    env_tick = 1'b1;
    step();
    env_tick = 1'b0;
    ev_valid = 1'b1;
    ev_voice = 3'd3;
    ev_gate  = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      check($sformatf("hs_ev_ready_T%0d", c), {31'd0, ev_ready}, 32'd0);
      if (c == 8) check("hs_v7_before", voice_volumes[7], 32'd0);
      step();
    end
    check("hs_ev_ready_T9", {31'd0, ev_ready}, 32'd1);
    check("hs_v7_T9", voice_volumes[7], 32'h4000);
    check("hs_v3_not_yet", {31'd0, active[3]}, 32'd0);
    step();
    ev_valid = 1'b0;
    check("hs_v3_accepted", {31'd0, active[3]}, 32'd1);
    check("hs_v3_level", voice_volumes[3], 32'd0);

    // Retrigger from RELEASE and tick overrun on voice 2
    do_reset();
    set_rates(32'h8000, 32'h8000, 32'h8000, 32'h2000);
    send_event(3'd2, 1'b1);
    do_tick();
    check("rt_attack1", voice_volumes[2], 32'h8000);
    do_tick();
    check("rt_full", voice_volumes[2], 32'h10000);
    do_tick();
    check("rt_sustain", voice_volumes[2], 32'h8000);
    send_event(3'd2, 1'b0);
    do_tick();
    check("rt_release", voice_volumes[2], 32'h6000);
    attack_rate = 32'h4000;
    send_event(3'd2, 1'b1);
    check("rt_no_level_jump", voice_volumes[2], 32'h6000);
    check("rt_overrun_clear", {31'd0, tick_overrun}, 32'd0);
    env_tick = 1'b1;
    step();
    env_tick = 1'b0;
    step();
    step();
    env_tick = 1'b1;
    step();
    env_tick = 1'b0;
    check("ov_flag_set", {31'd0, tick_overrun}, 32'd1);
    repeat (5) step();
    check("rt_retrigger_level", voice_volumes[2], 32'hA000);
    check("ov_scan_ended", {31'd0, ev_ready}, 32'd1);
    step();
    check("ov_no_extra_scan", {31'd0, ev_ready}, 32'd1);
    repeat (9) step();
    check("ov_level_stable", voice_volumes[2], 32'hA000);
    check("ov_sticky", {31'd0, tick_overrun}, 32'd1);

    // Reset in the middle of a scan
    send_event(3'd5, 1'b1);
    env_tick = 1'b1;
    step();
    env_tick = 1'b0;
    repeat (3) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_all_quiet("midscan_reset");
    check("midscan_overrun", {31'd0, tick_overrun}, 32'd0);
    repeat (10) step();
    check_all_quiet("post_reset");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
